cu_pipelined: RTL

Pipelined RV32I control unit for the ID stage, the registered successor of the combinational decoder. Decodes the IF/ID instruction and registers the resulting control bundle into the ID/EX boundary. Detects load-use hazards and inserts bubbles. Honours EX-stage flushes. Optionally sequences multi-cycle RV32M operations by stalling the front end for a parametrised latency.

---
 rtl/cu_pipelined_pkg.sv | 83 ++++++++
 rtl/cu_pipelined_decode.sv | 162 ++++++++++++++++
 rtl/cu_pipelined.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cu_pipelined_pkg.sv
// rv32i: shared RV32I/M control definitions for the ID-stage control unit and datapath.
// Opcodes, immediate selects, ALU op codes, the ID/EX control bundle and CU FSM states.
package rv32i;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam int unsigned IMMEDIATE_SELECTION_WIDTH = 3;
  typedef logic [IMMEDIATE_SELECTION_WIDTH-1:0] imm_sel_t;

  localparam imm_sel_t IMM_I = imm_sel_t'(0);
  localparam imm_sel_t IMM_S = imm_sel_t'(1);
  localparam imm_sel_t IMM_B = imm_sel_t'(2);
  localparam imm_sel_t IMM_U = imm_sel_t'(3);
  localparam imm_sel_t IMM_J = imm_sel_t'(4);

  // MUL covers MUL/MULH/MULHSU/MULHU and DIV covers DIV/DIVU/REM/REMU;
  // the variant travels in the funct3 field of the bundle (dmem_mode).
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10,
    ALU_MUL    = 4'd11,
    ALU_DIV    = 4'd12
  } alu_op_t;

  typedef struct packed {
    imm_sel_t    imm_type;
    logic        dmem_write;
    logic        dmem_read;
    logic [2:0]  dmem_mode;
    logic        rf_write;
    logic        alu_src;
    logic        wb_sel;
    logic        branch;
    logic        jump;
    logic        jalr;
    alu_op_t     alu_op;
    logic [4:0]  rd;
    logic        illegal;
  } ctrl_t;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } cu_state_t;

  // Integer ALU op from funct3; alt selects SUB/SRA.
  function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/cu_pipelined_decode.sv
// cu_decode: combinational RV32I(+M) instruction decoder.
// Produces the control bundle, register-use flags for hazard detection and,
// when RV32M_EN is defined, an M-op flag. Illegal encodings zero all strobes.
module cu_decode
  import rv32i::*;
(
  input  logic [31:0] i_instruction,
  output ctrl_t       o_ctrl,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic        o_use_rs1,
  output logic        o_use_rs2
`ifdef RV32M_EN
  ,
  output logic        o_is_m
`endif
);

  logic [6:0] w_opcode;
  logic [6:0] w_funct7;
  logic [2:0] w_funct3;
  logic [4:0] w_rd;
  logic       w_legal;

  assign w_opcode = i_instruction[6:0];
  assign w_rd     = i_instruction[11:7];
  assign w_funct3 = i_instruction[14:12];
  assign o_rs1    = i_instruction[19:15];
  assign o_rs2    = i_instruction[24:20];
  assign w_funct7 = i_instruction[31:25];

  // Opcode/funct decode into the control bundle with all-zero defaults.
  always_comb begin
    o_ctrl    = '0;
    o_use_rs1 = 1'b0;
    o_use_rs2 = 1'b0;
    w_legal   = 1'b0;
`ifdef RV32M_EN
    o_is_m    = 1'b0;
`endif
    case (w_opcode)
      OPC_LUI: begin
        w_legal         = 1'b1;
        o_ctrl.imm_type = IMM_U;
        o_ctrl.rf_write = 1'b1;
        o_ctrl.alu_src  = 1'b1;
        o_ctrl.alu_op   = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        w_legal         = 1'b1;
        o_ctrl.imm_type = IMM_U;
        o_ctrl.rf_write = 1'b1;
        o_ctrl.alu_src  = 1'b1;
        o_ctrl.alu_op   = ALU_ADD;
      end
      OPC_JAL: begin
        w_legal         = 1'b1;
        o_ctrl.imm_type = IMM_J;
        o_ctrl.rf_write = 1'b1;
        o_ctrl.jump     = 1'b1;
        o_ctrl.alu_src  = 1'b1;
        o_ctrl.alu_op   = ALU_ADD;
      end
      OPC_JALR: begin
        w_legal         = (w_funct3 == 3'b000);
        o_use_rs1       = 1'b1;
        o_ctrl.imm_type = IMM_I;
        o_ctrl.rf_write = 1'b1;
        o_ctrl.jump     = 1'b1;
        o_ctrl.jalr     = 1'b1;
        o_ctrl.alu_src  = 1'b1;
        o_ctrl.alu_op   = ALU_ADD;
      end
      OPC_BRANCH: begin
        w_legal         = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
        o_use_rs1       = 1'b1;
        o_use_rs2       = 1'b1;
        o_ctrl.imm_type = IMM_B;
        o_ctrl.branch   = 1'b1;
        o_ctrl.alu_op   = ALU_SUB;
      end
      OPC_LOAD: begin
        w_legal          = w_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        o_use_rs1        = 1'b1;
        o_ctrl.imm_type  = IMM_I;
        o_ctrl.dmem_read = 1'b1;
        o_ctrl.dmem_mode = w_funct3;
        o_ctrl.rf_write  = 1'b1;
        o_ctrl.wb_sel    = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_op    = ALU_ADD;
      end
      OPC_STORE: begin
        w_legal           = w_funct3 inside {3'b000, 3'b001, 3'b010};
        o_use_rs1         = 1'b1;
        o_use_rs2         = 1'b1;
        o_ctrl.imm_type   = IMM_S;
        o_ctrl.dmem_write = 1'b1;
        o_ctrl.dmem_mode  = w_funct3;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.alu_op     = ALU_ADD;
      end
      OPC_OP_IMM: begin
        // Shift-immediates reuse funct7 as a qualifier; everything else is free imm.
        if (w_funct3 == 3'b001)
          w_legal = (w_funct7 == F7_BASE);
        else if (w_funct3 == 3'b101)
          w_legal = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
        else
          w_legal = 1'b1;
        o_use_rs1       = 1'b1;
        o_ctrl.imm_type = IMM_I;
        o_ctrl.rf_write = 1'b1;
        o_ctrl.alu_src  = 1'b1;
        o_ctrl.alu_op   = alu_op_from_f3(w_funct3, (w_funct3 == 3'b101) && (w_funct7 == F7_ALT));
      end
      OPC_OP: begin
        o_use_rs1       = 1'b1;
        o_use_rs2       = 1'b1;
        o_ctrl.rf_write = 1'b1;
        if (w_funct7 == F7_BASE) begin
          w_legal       = 1'b1;
          o_ctrl.alu_op = alu_op_from_f3(w_funct3, 1'b0);
        end else if ((w_funct7 == F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))) begin
          w_legal       = 1'b1;
          o_ctrl.alu_op = alu_op_from_f3(w_funct3, 1'b1);
        end
`ifdef RV32M_EN
        else if (w_funct7 == F7_MULDIV) begin
          w_legal          = 1'b1;
          o_is_m           = 1'b1;
          o_ctrl.dmem_mode = w_funct3;
          o_ctrl.alu_op    = w_funct3[2] ? ALU_DIV : ALU_MUL;
        end
`endif
      end
      OPC_MISC_MEM: begin
        // FENCE is a no-op on this in-order core.
        w_legal = 1'b1;
      end
      OPC_SYSTEM: begin
        // ECALL/EBREAK carry no datapath strobes; trapping is handled elsewhere.
        w_legal = (w_funct3 == 3'b000);
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase

    if (!w_legal) begin
      o_ctrl         = '0;
      o_ctrl.illegal = 1'b1;
      o_use_rs1      = 1'b0;
      o_use_rs2      = 1'b0;
`ifdef RV32M_EN
      o_is_m         = 1'b0;
`endif
    end
    o_ctrl.rd = o_ctrl.rf_write ? w_rd : '0;
  end

endmodule

// File: rtl/cu_pipelined.sv
// cu_pipelined: registered ID-stage control unit (ID/EX control boundary).
// Load-use bubbles, EX flush handling and, with RV32M_EN defined, a RUN/BUSY
// sequencer that stalls the front end while a multi-cycle M op occupies EX.
module cu_pipelined
  import rv32i::*;
#(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned CNT_W      = $clog2(DIV_CYCLES + 1)
)(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 id_valid,
  input  logic [31:0]                          instruction,
  input  logic                                 flush,
  output logic                                 stall,
  output logic                                 ex_valid,
  output logic [IMMEDIATE_SELECTION_WIDTH-1:0] ex_imm_type,
  output logic                                 ex_dmem_write,
  output logic                                 ex_dmem_read,
  output logic [2:0]                           ex_dmem_mode,
  output logic                                 ex_rf_write,
  output logic                                 ex_alu_src,
  output logic                                 ex_wb_sel,
  output logic                                 ex_branch,
  output logic                                 ex_jump,
  output logic                                 ex_jalr,
  output logic [3:0]                           ex_alu_op,
  output logic [4:0]                           ex_rd,
  output logic                                 ex_illegal,
  output logic                                 ex_muldiv_busy,
  output logic                                 ex_muldiv_done
);

  if ((MUL_CYCLES < 1) || (DIV_CYCLES < 1)) begin : g_bad_latency
    $error("cu_pipelined: MUL_CYCLES and DIV_CYCLES must be >= 1");
  end
  if ((CNT_W < 1) || (CNT_W > 31) ||
      ((32'd1 << CNT_W) < DIV_CYCLES) || ((32'd1 << CNT_W) < MUL_CYCLES)) begin : g_bad_cnt_w
    $error("cu_pipelined: CNT_W too narrow for the configured latencies");
  end

  ctrl_t      w_dec;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_use_rs1;
  logic       w_use_rs2;
  logic       w_hazard;

  ctrl_t      r_ctrl;
  ctrl_t      w_ctrl_nxt;
  logic       r_valid;
  logic       w_valid_nxt;

`ifdef RV32M_EN
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  cu_state_t        r_state;
  cu_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_load;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_is_m;
`endif

  cu_decode u_decode (
    .i_instruction (instruction),
    .o_ctrl        (w_dec),
    .o_rs1         (w_rs1),
    .o_rs2         (w_rs2),
    .o_use_rs1     (w_use_rs1),
    .o_use_rs2     (w_use_rs2)
`ifdef RV32M_EN
    ,
    .o_is_m        (w_is_m)
`endif
  );

  // A live load in EX whose rd (never x0) feeds a used source of the ID instruction.
  assign w_hazard = id_valid && r_valid && r_ctrl.dmem_read && (r_ctrl.rd != 5'd0) &&
                    ((w_use_rs1 && (w_rs1 == r_ctrl.rd)) || (w_use_rs2 && (w_rs2 == r_ctrl.rd)));

`ifdef RV32M_EN
  assign w_load = (w_dec.alu_op == ALU_DIV) ? DIV_LOAD : MUL_LOAD;
`endif

  // Next-state, ID/EX next value and stall; flush outranks BUSY and hazards.
  always_comb begin
    w_ctrl_nxt  = r_ctrl;
    w_valid_nxt = r_valid;
    stall       = 1'b0;
`ifdef RV32M_EN
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
`endif
    if (flush) begin
      w_ctrl_nxt  = '0;
      w_valid_nxt = 1'b0;
`ifdef RV32M_EN
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
`endif
    end
`ifdef RV32M_EN
    else if (r_state == BUSY) begin
      // The done pulse is registered so it lands on the op's last EX cycle,
      // which is the first RUN cycle after BUSY.
      stall     = 1'b1;
      w_cnt_nxt = r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        w_state_nxt = RUN;
        w_done_nxt  = 1'b1;
      end
    end
`endif
    else if (w_hazard) begin
      stall       = 1'b1;
      w_ctrl_nxt  = '0;
      w_valid_nxt = 1'b0;
    end else begin
      w_valid_nxt = id_valid;
      w_ctrl_nxt  = id_valid ? w_dec : '0;
`ifdef RV32M_EN
      if (id_valid && w_is_m) begin
        w_cnt_nxt = w_load;
        if (w_load != '0)
          w_state_nxt = BUSY;
        else
          w_done_nxt = 1'b1;
      end
`endif
    end
  end

  // ID/EX register and FSM state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
`ifdef RV32M_EN
      r_state <= RUN;
      r_cnt   <= '0;
      r_done  <= 1'b0;
`endif
    end else begin
      r_ctrl  <= w_ctrl_nxt;
      r_valid <= w_valid_nxt;
`ifdef RV32M_EN
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
`endif
    end
  end

  assign ex_valid      = r_valid;
  assign ex_imm_type   = r_ctrl.imm_type;
  assign ex_dmem_write = r_ctrl.dmem_write;
  assign ex_dmem_read  = r_ctrl.dmem_read;
  assign ex_dmem_mode  = r_ctrl.dmem_mode;
  assign ex_rf_write   = r_ctrl.rf_write;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_wb_sel     = r_ctrl.wb_sel;
  assign ex_branch     = r_ctrl.branch;
  assign ex_jump       = r_ctrl.jump;
  assign ex_jalr       = r_ctrl.jalr;
  assign ex_alu_op     = r_ctrl.alu_op;
  assign ex_rd         = r_ctrl.rd;
  assign ex_illegal    = r_ctrl.illegal;

`ifdef RV32M_EN
  assign ex_muldiv_busy = (r_state == BUSY);
  assign ex_muldiv_done = r_done;
`else
  assign ex_muldiv_busy = 1'b0;
  assign ex_muldiv_done = 1'b0;
`endif

endmodule
